// File: rtl/usr_pkg.sv
// Shared encodings for the parametrised universal shift register.
// Mode select values and burst FSM states.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_SHL   = 3'b011;
    localparam logic [2:0] MODE_ROTR  = 3'b100;
    localparam logic [2:0] MODE_ROTL  = 3'b101;
    localparam logic [2:0] MODE_ASHR  = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } usr_state_t;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst-rotate controller: FSM, down-counter and direction latch.
// Drives rot_en/rot_dir for the register datapath during a burst.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             c,
    input  logic             r,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    input  logic             bd,
    output logic             idle,
    output logic             busy,
    output logic             done,
    output logic             rot_en,
    output logic             rot_dir
);

    usr_state_t       state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             dir_q, dir_d;

    always_ff @(posedge c) begin
        if (r) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        dir_d     = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    counter_d = cnt;
                    dir_d     = bd;
                    state_d   = (cnt != '0) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                counter_d = counter_q - CNT_W'(1);
                if (counter_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign idle    = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_BUSY);
    assign done    = (state_q == ST_DONE);
    assign rot_en  = busy;
    assign rot_dir = dir_q;

endmodule

// File: rtl/usr_param.sv
// Parametrised universal shift register with burst-rotate engine.
// Optional parity output enabled by defining USR_PARITY_EN.
module usr_param
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             c,
    input  logic             r,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] x,
    input  logic             z,
    input  logic [CNT_W-1:0] cnt,
    input  logic             bd,
    output logic [WIDTH-1:0] y,
    output logic             sor,
    output logic             sol,
`ifdef USR_PARITY_EN
    output logic             par,
`endif
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] y_q, y_d;
    logic             idle, start, rot_en, rot_dir;

    assign start = idle && (s == MODE_BURST);

    usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .c       (c),
        .r       (r),
        .start   (start),
        .cnt     (cnt),
        .bd      (bd),
        .idle    (idle),
        .busy    (busy),
        .done    (done),
        .rot_en  (rot_en),
        .rot_dir (rot_dir)
    );

    always_ff @(posedge c) begin
        if (r) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    // Mode select only acts while idle; a burst owns the register otherwise.
    always_comb begin
        y_d = y_q;
        if (idle) begin
            unique case (s)
                MODE_HOLD:  y_d = y_q;
                MODE_LOAD:  y_d = x;
                MODE_SHR:   y_d = {z, y_q[WIDTH-1:1]};
                MODE_SHL:   y_d = {y_q[WIDTH-2:0], z};
                MODE_ROTR:  y_d = {y_q[0], y_q[WIDTH-1:1]};
                MODE_ROTL:  y_d = {y_q[WIDTH-2:0], y_q[WIDTH-1]};
                MODE_ASHR:  y_d = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
                MODE_BURST: y_d = y_q;
                default:    y_d = y_q;
            endcase
        end else if (rot_en) begin
            y_d = rot_dir ? {y_q[WIDTH-2:0], y_q[WIDTH-1]}
                          : {y_q[0], y_q[WIDTH-1:1]};
        end
    end

    assign y   = y_q;
    assign sor = y_q[0];
    assign sol = y_q[WIDTH-1];
`ifdef USR_PARITY_EN
    assign par = ^y_q;
`endif

endmodule
